// File: rtl/rv_pkg.sv
// Opcode constants and operand-use decode shared by the operand fetch stage.
package rv_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic rd_we;
    } src_use_t;

    function automatic src_use_t decode_use(input logic [6:0] opcode);
        src_use_t u;
        u = '0;
        case (opcode)
            OPC_OP, OPC_OP32:                              u = '{use_rs1: 1'b1, use_rs2: 1'b1, rd_we: 1'b1};
            OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR:    u = '{use_rs1: 1'b1, use_rs2: 1'b0, rd_we: 1'b1};
            OPC_STORE, OPC_BRANCH:                         u = '{use_rs1: 1'b1, use_rs2: 1'b1, rd_we: 1'b0};
            OPC_LUI, OPC_AUIPC, OPC_JAL:                   u = '{use_rs1: 1'b0, use_rs2: 1'b0, rd_we: 1'b1};
            default:                                       u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/op_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, x0 never busy.
module op_scoreboard #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             flush,
    input  logic [IDX_W-1:0] qry_a_idx,
    input  logic [IDX_W-1:0] qry_b_idx,
    output logic             busy_a,
    output logic             busy_b
);

    localparam int NREG = 1 << IDX_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en)
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
        if (flush)
            busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_a = busy[qry_a_idx];
    assign busy_b = busy[qry_b_idx];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decodes sources, checks RAW hazards against the scoreboard and loads the ID/EX register.
// Optional build macro WB_BYPASS_EN forwards same-cycle writeback data instead of stalling.
module operand_fetch
    import rv_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5,
    parameter int INSTR_WIDTH        = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          instr_valid_in,
    output logic                          instr_ready_out,
    input  logic [INSTR_WIDTH-1:0]        instr_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] pc_in,
    output logic [REG_MEM_DEPTH_POW-1:0]  rs1_out,
    output logic [REG_MEM_DEPTH_POW-1:0]  rs2_out,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] reg_data1_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] reg_data2_in,
    input  logic                          wb_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]  wb_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] wb_data_in,
    input  logic                          flush_in,
    output logic                          ex_valid_out,
    input  logic                          ex_ready_in,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] ex_op1_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] ex_op2_out,
    output logic [REG_MEM_DEPTH_POW-1:0]  ex_rd_out,
    output logic                          ex_rd_we_out,
    output logic [INSTR_WIDTH-1:0]        ex_instr_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] ex_pc_out
);

    localparam int DATA_W = 1 << REG_DATA_WIDTH_POW;
    localparam int IDX_W  = REG_MEM_DEPTH_POW;

    src_use_t          src_use;
    logic [IDX_W-1:0]  rs1, rs2, rd;
    logic              rd_we;
    logic              busy1, busy2;
    logic              haz1, haz2, hazard;
    logic              slot_free, accept;
    logic [DATA_W-1:0] op1, op2;

    logic              vld_p1;
    logic [DATA_W-1:0] op1_p1, op2_p1, pc_p1;
    logic [IDX_W-1:0]  rd_p1;
    logic              rd_we_p1;
    logic [INSTR_WIDTH-1:0] instr_p1;

    assign src_use = decode_use(instr_in[6:0]);
    assign rs1     = instr_in[19:15];
    assign rs2     = instr_in[24:20];
    assign rd      = instr_in[11:7];
    assign rd_we   = src_use.rd_we && (rd != '0);
    assign rs1_out = rs1;
    assign rs2_out = rs2;

    op_scoreboard #(.IDX_W(IDX_W)) u_scoreboard (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .set_en    (accept && rd_we),
        .set_idx   (rd),
        .clr_en    (wb_valid_in),
        .clr_idx   (wb_rd_in),
        .flush     (flush_in),
        .qry_a_idx (rs1),
        .qry_b_idx (rs2),
        .busy_a    (busy1),
        .busy_b    (busy2)
    );

`ifdef WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wb_valid_in && (wb_rd_in == rs1);
    assign byp2 = wb_valid_in && (wb_rd_in == rs2);
    assign haz1 = src_use.use_rs1 && (rs1 != '0) && busy1 && !byp1;
    assign haz2 = src_use.use_rs2 && (rs2 != '0) && busy2 && !byp2;
    assign op1  = (rs1 == '0) ? '0 : ((busy1 && byp1) ? wb_data_in : reg_data1_in);
    assign op2  = (rs2 == '0) ? '0 : ((busy2 && byp2) ? wb_data_in : reg_data2_in);
`else
    // Without forwarding the writeback lands in reg_file at this edge, so the retry next cycle reads it.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_in;
    assign haz1 = src_use.use_rs1 && (rs1 != '0) && busy1;
    assign haz2 = src_use.use_rs2 && (rs2 != '0) && busy2;
    assign op1  = (rs1 == '0) ? '0 : reg_data1_in;
    assign op2  = (rs2 == '0) ? '0 : reg_data2_in;
`endif

    assign hazard          = haz1 || haz2;
    assign slot_free       = !vld_p1 || ex_ready_in;
    assign instr_ready_out = slot_free && !hazard && !flush_in;
    assign accept          = instr_valid_in && instr_ready_out;

    // ID/EX register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1   <= 1'b0;
            op1_p1   <= '0;
            op2_p1   <= '0;
            pc_p1    <= '0;
            rd_p1    <= '0;
            rd_we_p1 <= 1'b0;
            instr_p1 <= '0;
        end else if (flush_in) begin
            vld_p1   <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            op1_p1   <= op1;
            op2_p1   <= op2;
            pc_p1    <= pc_in;
            rd_p1    <= rd;
            rd_we_p1 <= rd_we;
            instr_p1 <= instr_in;
        end else if (ex_ready_in) begin
            vld_p1   <= 1'b0;
        end
    end

    assign ex_valid_out = vld_p1;
    assign ex_op1_out   = op1_p1;
    assign ex_op2_out   = op2_p1;
    assign ex_pc_out    = pc_p1;
    assign ex_rd_out    = rd_p1;
    assign ex_rd_we_out = rd_we_p1;
    assign ex_instr_out = instr_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hazard, backpressure and flush sequences.
module tb_operand_fetch;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2;
    logic [63:0] d1, d2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_op1, ex_op2, ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [31:0] ex_instr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .instr_valid_in  (instr_valid),
        .instr_ready_out (instr_ready),
        .instr_in        (instr),
        .pc_in           (pc),
        .rs1_out         (rs1),
        .rs2_out         (rs2),
        .reg_data1_in    (d1),
        .reg_data2_in    (d2),
        .wb_valid_in     (wb_valid),
        .wb_rd_in        (wb_rd),
        .wb_data_in      (wb_data),
        .flush_in        (flush),
        .ex_valid_out    (ex_valid),
        .ex_ready_in     (ex_ready),
        .ex_op1_out      (ex_op1),
        .ex_op2_out      (ex_op2),
        .ex_rd_out       (ex_rd),
        .ex_rd_we_out    (ex_rd_we),
        .ex_instr_out    (ex_instr),
        .ex_pc_out       (ex_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] ins(input logic [6:0] op, input logic [4:0] rd_f,
                                        input logic [4:0] rs1_f, input logic [4:0] rs2_f);
        return {7'b0, rs2_f, rs1_f, 3'b0, rd_f, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clean();
        @(negedge clk);
        instr_valid = 1'b0;
        wb_valid    = 1'b0;
        ex_ready    = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ins(OPC_OP, 5'd3, 5'd1, 5'd2), 64'd5, 64'd7, 64'd5, 64'd7, 5'd3, 1'b1};
        vecs[1] = '{ins(OPC_STORE, 5'd0, 5'd0, 5'd7), 64'hDEAD, 64'h77, 64'd0, 64'h77, 5'd0, 1'b0};
        vecs[2] = '{ins(OPC_OPIMM, 5'd5, 5'd0, 5'd1), 64'hDEAD, 64'h99, 64'd0, 64'h99, 5'd5, 1'b1};
        vecs[3] = '{ins(OPC_LUI, 5'd8, 5'd3, 5'd4), 64'h11, 64'h22, 64'h11, 64'h22, 5'd8, 1'b1};
        vecs[4] = '{ins(OPC_OP, 5'd0, 5'd1, 5'd2), 64'h1, 64'h2, 64'h1, 64'h2, 5'd0, 1'b0};
        vecs[5] = '{ins(OPC_BRANCH, 5'd0, 5'd6, 5'd7), 64'h66, 64'h77, 64'h66, 64'h77, 5'd0, 1'b0};
        vecs[6] = '{ins(7'b1111111, 5'd9, 5'd1, 5'd2), 64'h3, 64'h4, 64'h3, 64'h4, 5'd9, 1'b0};
        vecs[7] = '{ins(OPC_OP, 5'd2, 5'd0, 5'd0), 64'hDEAD, 64'hDEAD, 64'd0, 64'd0, 5'd2, 1'b1};
        vecs[8] = '{ins(OPC_OP32, 5'd10, 5'd11, 5'd12), 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 5'd10, 1'b1};

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0; d1 = '0; d2 = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_op1", ex_op1, 64'd0);
        chk("rst_ex_pc", ex_pc, 64'd0);
        chk("rst_ex_rd_we", 64'(ex_rd_we), 64'd0);
        chk("rst_ex_instr", 64'(ex_instr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: each vector issued from an empty stage and scoreboard
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr = vecs[i].instr;
            d1 = vecs[i].d1;
            d2 = vecs[i].d2;
            pc = 64'h1000 + 64'(i * 4);
            #1;
            chk("vec_rs1", 64'(rs1), 64'(vecs[i].instr[19:15]));
            chk("vec_rs2", 64'(rs2), 64'(vecs[i].instr[24:20]));
            chk("vec_ready", 64'(instr_ready), 64'd1);
            @(posedge clk);
            #1;
            chk("vec_ex_valid", 64'(ex_valid), 64'd1);
            chk("vec_op1", ex_op1, vecs[i].op1);
            chk("vec_op2", ex_op2, vecs[i].op2);
            chk("vec_rd", 64'(ex_rd), 64'(vecs[i].rd));
            chk("vec_rd_we", 64'(ex_rd_we), 64'(vecs[i].rd_we));
            chk("vec_instr", 64'(ex_instr), 64'(vecs[i].instr));
            chk("vec_pc", ex_pc, 64'h1000 + 64'(i * 4));
            clean();
        end

        // RAW hazard on x5 resolved by writeback
        @(negedge clk);
        instr_valid = 1'b1; instr = ins(OPC_OPIMM, 5'd5, 5'd0, 5'd1); d1 = '0; d2 = '0;
        @(posedge clk);
        #1 chk("raw_first_rd", 64'(ex_rd), 64'd5);
        @(negedge clk);
        instr = ins(OPC_OP, 5'd6, 5'd5, 5'd5); d1 = 64'hBAD; d2 = 64'hBAD;
        #1 chk("raw_stall", 64'(instr_ready), 64'd0);
        @(posedge clk);
        #1 chk("raw_drain", 64'(ex_valid), 64'd0);
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'd1;
`ifdef WB_BYPASS_EN
        #1 chk("raw_byp_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1;
`else
        #1 chk("raw_wb_cycle_stall", 64'(instr_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b0; d1 = 64'd1; d2 = 64'd1;
        #1 chk("raw_retry_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1;
`endif
        chk("raw_ex_valid", 64'(ex_valid), 64'd1);
        chk("raw_op1", ex_op1, 64'd1);
        chk("raw_op2", ex_op2, 64'd1);
        chk("raw_rd", 64'(ex_rd), 64'd6);
        clean();

        // Backpressure with a second instruction waiting
        @(negedge clk);
        ex_ready = 1'b0; instr_valid = 1'b1;
        instr = ins(OPC_OP, 5'd3, 5'd1, 5'd2); d1 = 64'd5; d2 = 64'd7;
        @(posedge clk);
        #1 chk("bp_first_valid", 64'(ex_valid), 64'd1);
        @(negedge clk);
        instr = ins(OPC_LUI, 5'd8, 5'd0, 5'd0); d1 = '0; d2 = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready_low", 64'(instr_ready), 64'd0);
            chk("bp_hold_op1", ex_op1, 64'd5);
            chk("bp_hold_rd", 64'(ex_rd), 64'd3);
            @(posedge clk);
        end
        @(negedge clk);
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_second_valid", 64'(ex_valid), 64'd1);
        chk("bp_second_rd", 64'(ex_rd), 64'd8);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 chk("bp_drain", 64'(ex_valid), 64'd0);
        clean();

        // Accept LW x9 while x9 is written back in the same cycle: set wins
        @(negedge clk);
        instr_valid = 1'b1; instr = ins(OPC_LOAD, 5'd9, 5'd1, 5'd0); d1 = 64'h40; d2 = '0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
        #1 chk("setclr_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        chk("setclr_rd_we", 64'(ex_rd_we), 64'd1);
        @(negedge clk);
        instr = ins(OPC_OP, 5'd10, 5'd9, 5'd0);
        #1 chk("setclr_busy_kept", 64'(instr_ready), 64'd0);
        clean();

        // Flush clears a pending writer and the ID/EX slot
        @(negedge clk);
        ex_ready = 1'b0; instr_valid = 1'b1; instr = ins(OPC_OPIMM, 5'd4, 5'd0, 5'd0);
        @(posedge clk);
        #1 chk("fl_pre_valid", 64'(ex_valid), 64'd1);
        @(negedge clk);
        flush = 1'b1; instr = ins(OPC_OP, 5'd1, 5'd4, 5'd4); d1 = 64'd3; d2 = 64'd3;
        #1 chk("fl_no_accept", 64'(instr_ready), 64'd0);
        @(posedge clk);
        #1 chk("fl_ex_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0;
        #1 chk("fl_ready_after", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("fl_op1", ex_op1, 64'd3);
        chk("fl_rd", 64'(ex_rd), 64'd1);
        clean();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
